// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver/transmitter state encoding, bit timing
// constants and the 3-sample vote helper.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned VOTE_FIRST  = 7;
    localparam int unsigned VOTE_LAST   = 9;
    localparam int unsigned STOP_BIT    = 9;
    localparam logic [15:0] DEFAULT_DIV = 16'd163;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spart_baud_tick.sv
// Baud tick generator: 16-bit down-counter that pulses tick every div clocks
// and restarts its period on load.
module spart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    // A load restarts the period, so a coincident terminal count is not a tick.
    assign tick = !load && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load || (cnt == '0)) begin
            cnt <= div - 16'd1;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart_rx_core.sv
// SPART serial receive engine: 16x oversampled 8N1 receiver with majority
// voting, framing/overrun detection and a single-entry valid/ready output.
module spart_rx_core #(
    parameter logic [15:0] DEFAULT_DIV = 16'd163,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] brg_div,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        rx_busy
);

    import spart_pkg::*;

    rx_state_t   state, state_nxt;
    logic        rxd_m, rxd_s, rxd_d, armed;
    logic        start_det, tick, decide, maj;
    logic        s_first, s_mid;
    logic [15:0] div_q, div_new, div_use;
    logic [7:0]  tick_cnt, tick_num, phase, bit_n;
    logic [7:0]  shift_reg;
    logic        shift_en, deliver, ferr_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b0;
            rxd_s <= 1'b0;
            rxd_d <= 1'b0;
            armed <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
            armed <= armed | rxd_s;
        end
    end

    assign start_det = (state == IDLE) && armed && rxd_d && !rxd_s;
    assign div_new   = (brg_div == '0) ? DEFAULT_DIV : brg_div;
    // The counter must see the new divisor in the same cycle it is latched.
    assign div_use   = start_det ? div_new : div_q;

    spart_baud_tick u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .load (start_det),
        .div  (div_use),
        .tick (tick)
    );

    // tick_num is the index of the tick being acted on this cycle.
    assign tick_num = tick_cnt + 8'd1;
    assign phase    = tick_num % 8'(OVERSAMPLE);
    assign bit_n    = tick_num / 8'(OVERSAMPLE);
    assign decide   = tick && (state != IDLE) && (phase == 8'(VOTE_LAST));
    assign maj      = majority3(s_first, s_mid, rxd_s);
    assign rx_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            tick_cnt <= '0;
            s_first  <= 1'b0;
            s_mid    <= 1'b0;
        end else begin
            if (start_det) begin
                div_q    <= div_new;
                tick_cnt <= '0;
            end else if (tick && (state != IDLE)) begin
                tick_cnt <= tick_num;
                if (phase == 8'(VOTE_FIRST)) s_first <= rxd_s;
                if (phase == 8'(VOTE_FIRST + 1)) s_mid <= rxd_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        ferr_now  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_det) state_nxt = START;
            end
            START: begin
                if (decide) state_nxt = maj ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_n == 8'(STOP_BIT - 1)) state_nxt = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    state_nxt = IDLE;
                    deliver   = maj;
                    ferr_now  = !maj;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Right shift fills LSB-first: after eight data bits bit n-1 sits at [n-1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shift_reg <= '0;
        else if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_now;
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_rx_core.sv
// Self-checking bench for spart_rx_core: frame table with byte scoreboard plus
// hand sequences for timing, false start, overrun and reset corner cases.
`timescale 1ns/1ps
module tb_spart_rx_core;

    localparam int BIT_DEF  = 26077;
    localparam int BIT_FAST = 640;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [15:0] brg_div;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        rx_busy;

    spart_rx_core #(.DEFAULT_DIV(16'd163), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .brg_div   (brg_div),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    logic [8:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard sink: every accepted byte must match the oldest expected one.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            if (rx_valid && rx_ready) begin
                logic [8:0] e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h100;
                check("rx_data", {24'h0, rx_data}, {23'h0, e});
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bit_ns);
        end
        rxd = stop;
        #(bit_ns);
        rxd = 1'b1;
        #(bit_ns);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},   {24'h0, rx_data}, 32'h0);
        check({tag, "_rx_valid"},  {31'h0, rx_valid}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
        check({tag, "_overrun"},   {31'h0, overrun}, 32'h0);
        check({tag, "_rx_busy"},   {31'h0, rx_busy}, 32'h0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int f0, o0, t0, lat;

        tbl[0] = '{8'h5A, 1'b1, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1};
        tbl[2] = '{8'h96, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h81, 1'b1, 1'b0};

        // Line low through reset, then 0x55 at the default divisor.
        rst = 1'b0; rxd = 1'b0; rx_ready = 1'b1; brg_div = 16'd0;
        #100;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b1;
        #6500;
        check("low_line_busy", {31'h0, rx_busy}, 32'h0);
        rxd = 1'b1;
        #(BIT_DEF);
        f0 = ferr_cnt;
        exp_q.push_back(9'h055);
        send_frame(8'h55, 1'b1, BIT_DEF);
        check("low_line_drained", exp_q.size(), 0);
        check("low_line_ferr", ferr_cnt - f0, 0);

        // Idle then 0xAA: rx_valid edge latency = 2 sync + 1 detect + 153*D.
        brg_div = 16'd4;
        #6500;
        exp_q.push_back(9'h0AA);
        @(negedge clk);
        t0 = cyc;
        lat = -1;
        fork
            send_frame(8'hAA, 1'b1, BIT_FAST);
            begin
                for (int k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        check("valid_latency", lat, 3 + 153 * 4);
        check("idle_byte_drained", exp_q.size(), 0);

        // Frame table at D=4.
        foreach (tbl[i]) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (!tbl[i].exp_ferr) exp_q.push_back({1'b0, tbl[i].data});
            send_frame(tbl[i].data, tbl[i].stop, BIT_FAST);
            check("tbl_frame_err", ferr_cnt - f0, {31'h0, tbl[i].exp_ferr});
            check("tbl_overrun", ovr_cnt - o0, 0);
            check("tbl_drained", exp_q.size(), 0);
        end

        // False start: 500 ns glitch at the default divisor.
        brg_div = 16'd0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        @(negedge clk);
        t0 = cyc;
        rxd = 1'b0;
        #500;
        rxd = 1'b1;
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!rx_busy && (cyc - t0) > 10) begin
                lat = cyc - t0;
                break;
            end
        end
        check("false_start_busy_cycles", lat, 3 + 9 * 163);
        check("false_start_valid", {31'h0, rx_valid}, 32'h0);
        check("false_start_ferr", ferr_cnt - f0, 0);
        check("false_start_overrun", ovr_cnt - o0, 0);
        #(BIT_FAST);

        // Divisor change mid-frame must not disturb the frame in flight.
        brg_div = 16'd4;
        exp_q.push_back(9'h069);
        fork
            send_frame(8'h69, 1'b1, BIT_FAST);
            begin
                #2000;
                brg_div = 16'd9;
            end
        join
        brg_div = 16'd4;
        check("div_change_drained", exp_q.size(), 0);

        // Overrun: two frames back-to-back with the consumer stalled.
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(9'h011);
        send_frame(8'h11, 1'b1, BIT_FAST);
        send_frame(8'h22, 1'b1, BIT_FAST);
        check("overrun_count", ovr_cnt - o0, 1);
        check("overrun_valid", {31'h0, rx_valid}, 32'h1);
        check("overrun_data", {24'h0, rx_data}, 32'h11);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("overrun_consume_valid", {31'h0, rx_valid}, 32'h0);
        check("overrun_drained", exp_q.size(), 0);

        // Reset during data bit 4 with a byte still held.
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, BIT_FAST);
        check("pre_reset_valid", {31'h0, rx_valid}, 32'h1);
        rxd = 1'b0;
        #(BIT_FAST);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'h5A >> i) & 8'h01;
            #(BIT_FAST);
        end
        rxd = 1'b1;
        #(BIT_FAST / 2);
        check("pre_reset_busy", {31'h0, rx_busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        #(BIT_FAST);
        @(negedge clk);
        rst = 1'b1;
        rx_ready = 1'b1;
        #(2 * BIT_FAST);
        exp_q.push_back(9'h0C3);
        send_frame(8'hC3, 1'b1, BIT_FAST);
        check("post_reset_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
